// File: rtl/button_conditioner.sv
// Button conditioner: per-channel two-flop synchroniser, counter-based
// debounce, registered clean level and single-cycle press/release pulses.
// A change on the synchronised input is accepted only after it has differed
// from the accepted level for DEBOUNCE_CYCLES consecutive clock edges.
module button_conditioner #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release
);

  // Terminal count: the edge that sees this count with a still-differing
  // input is the DEBOUNCE_CYCLES-th consecutive differing edge.
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]     sync1_q;
  logic [N-1:0]     sync2_q;
  logic [N-1:0]     level_q,   level_d;
  logic [N-1:0]     press_q,   press_d;
  logic [N-1:0]     release_q, release_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  // Two-flop synchroniser; only sync2_q is used downstream.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce decision: accept, keep counting, or restart.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == TERM_CNT) begin
          level_d[i]   = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule
